// File: rtl/decode_stage.sv
// Multi-lane RV32I decode stage: per-lane decode, in-order illegal squashing,
// a registered main/skid buffer pair behind valid/ready, and a saturating
// illegal-instruction counter.
// Optional build macro DECODE_RVM_EN: decode the M extension as class MULDIV.

package decode_stage_pkg;
    localparam logic [3:0] CLS_NONE   = 4'd0;
    localparam logic [3:0] CLS_LUI    = 4'd1;
    localparam logic [3:0] CLS_AUIPC  = 4'd2;
    localparam logic [3:0] CLS_JAL    = 4'd3;
    localparam logic [3:0] CLS_JALR   = 4'd4;
    localparam logic [3:0] CLS_BRANCH = 4'd5;
    localparam logic [3:0] CLS_ALUI   = 4'd6;
    localparam logic [3:0] CLS_ALUR   = 4'd7;
    localparam logic [3:0] CLS_MULDIV = 4'd8;
    localparam logic [3:0] CLS_INV    = 4'd15;

    function automatic logic is_write(input logic [3:0] cls);
        return (cls == CLS_LUI)  || (cls == CLS_AUIPC) || (cls == CLS_JAL) ||
               (cls == CLS_JALR) || (cls == CLS_ALUI)  || (cls == CLS_ALUR) ||
               (cls == CLS_MULDIV);
    endfunction
endpackage

// Single-lane classifier; an unfetched lane reports NONE.
module decode_lane
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        fetched,
    output logic [3:0]  cls
);
    logic [6:0] op;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;

    assign op  = inst[6:0];
    assign rd  = inst[11:7];
    assign f3  = inst[14:12];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign f7  = inst[31:25];

    // Exact encoding match, then the rd = x0 legality rule, then fetch gating.
    always_comb begin
        cls = CLS_INV;
        case (op)
            7'b0110111: cls = CLS_LUI;
            7'b0010111: cls = CLS_AUIPC;
            7'b1101111: cls = CLS_JAL;
            7'b1100111: cls = (f3 == 3'd0) ? CLS_JALR : CLS_INV;
            7'b1100011: cls = (f3 == 3'd2 || f3 == 3'd3) ? CLS_INV : CLS_BRANCH;
            7'b0010011: begin
                if (f3 == 3'd1)
                    cls = (f7 == 7'b0000000) ? CLS_ALUI : CLS_INV;
                else if (f3 == 3'd5)
                    cls = (f7 == 7'b0000000 || f7 == 7'b0100000) ? CLS_ALUI : CLS_INV;
                else
                    cls = CLS_ALUI;
            end
            7'b0110011: begin
                if (f7 == 7'b0000000)
                    cls = CLS_ALUR;
                else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5))
                    cls = CLS_ALUR;
`ifdef DECODE_RVM_EN
                else if (f7 == 7'b0000001)
                    cls = CLS_MULDIV;
`endif
                else
                    cls = CLS_INV;
            end
            default: cls = CLS_INV;
        endcase
        // Writing x0 is only tolerated for jumps (link discard) and the
        // all-zero-register canonical NOP form.
        if (is_write(cls) && cls != CLS_JAL && cls != CLS_JALR &&
            rd == 5'd0 && (rs1 != 5'd0 || rs2 != 5'd0))
            cls = CLS_INV;
        if (!fetched)
            cls = CLS_NONE;
    end
endmodule

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [32*LANES-1:0]  inst_i,
    input  logic [LANES-1:0]     fetched_i,
    input  logic [31:0]          pc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [32*LANES-1:0]  out_inst_o,
    output logic [4*LANES-1:0]   out_cls_o,
    output logic [LANES-1:0]     out_regwrite_o,
    output logic [LANES-1:0]     out_illegal_o,
    output logic [31:0]          out_pc_o,
    output logic [CNT_W-1:0]     illegal_cnt_o
);
    typedef struct packed {
        logic [LANES-1:0][31:0] inst;
        logic [LANES-1:0][3:0]  cls;
        logic [LANES-1:0]       rw;
        logic [LANES-1:0]       ill;
        logic [31:0]            pc;
    } bundle_t;

    logic [LANES-1:0][31:0] inst_l;
    logic [LANES-1:0][3:0]  lane_cls;
    bundle_t                dec;
    bundle_t                main_q;
    bundle_t                skid_q;
    logic                   main_v;
    logic                   skid_v;
    logic                   seen;
    logic                   accept;
    logic                   drain;
    logic [CNT_W-1:0]       cnt;

    assign inst_l = inst_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        decode_lane u_lane (
            .inst    (inst_l[k]),
            .fetched (fetched_i[k]),
            .cls     (lane_cls[k])
        );
    end

    // Keep lanes up to and including the first illegal one; later lanes die.
    always_comb begin
        seen     = 1'b0;
        dec      = '0;
        dec.inst = inst_l;
        dec.pc   = pc_i;
        for (int k = 0; k < LANES; k++) begin
            if (!seen)
                dec.cls[k] = lane_cls[k];
            dec.ill[k] = (dec.cls[k] == CLS_INV);
            dec.rw[k]  = is_write(dec.cls[k]);
            if (dec.ill[k])
                seen = 1'b1;
        end
    end

    // in_ready is a pure flop output: ready exactly while the skid is empty.
    assign in_ready_o = ~skid_v;
    assign accept     = in_valid_i && !skid_v;
    assign drain      = main_v && out_ready_i;

    // Main/skid buffer: skid drains into main first so order is preserved.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || drain) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    // Squashing leaves at most one illegal lane, so each transfer adds 0 or 1.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (drain && (|main_q.ill) && cnt != {CNT_W{1'b1}})
            cnt <= cnt + CNT_W'(1);
    end

    assign out_valid_o    = main_v;
    assign out_inst_o     = main_q.inst;
    assign out_cls_o      = main_q.cls;
    assign out_regwrite_o = main_q.rw;
    assign out_illegal_o  = main_q.ill;
    assign out_pc_o       = main_q.pc;
    assign illegal_cnt_o  = cnt;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_decode_stage;
    localparam int L  = 2;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, out_ready;
    logic [32*L-1:0] inst;
    logic [L-1:0]    fetched;
    logic [31:0]     pc;
    logic            in_ready, out_valid;
    logic [32*L-1:0] out_inst;
    logic [4*L-1:0]  out_cls;
    logic [L-1:0]    out_rw, out_ill;
    logic [31:0]     out_pc;
    logic [CW-1:0]   cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [32*L-1:0] inst;
        logic [4*L-1:0]  cls;
        logic [L-1:0]    rw;
        logic [L-1:0]    ill;
        logic [31:0]     pc;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;

    decode_stage #(.LANES(L), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .fetched_i(fetched), .pc_i(pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_inst_o(out_inst), .out_cls_o(out_cls),
        .out_regwrite_o(out_rw), .out_illegal_o(out_ill),
        .out_pc_o(out_pc), .illegal_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference classification written straight from the ISA rules.
    function automatic int ref_cls(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int c = 15;
        if (op == 7'h37) c = 1;
        if (op == 7'h17) c = 2;
        if (op == 7'h6F) c = 3;
        if (op == 7'h67 && f3 == 0) c = 4;
        if (op == 7'h63 && !(f3 inside {3'd2, 3'd3})) c = 5;
        if (op == 7'h13) begin
            if (f3 == 1) c = (f7 == 0) ? 6 : 15;
            else if (f3 == 5) c = (f7 == 0 || f7 == 7'h20) ? 6 : 15;
            else c = 6;
        end
        if (op == 7'h33) begin
            if (f7 == 0) c = 7;
            if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) c = 7;
`ifdef DECODE_RVM_EN
            if (f7 == 7'h01) c = 8;
`endif
        end
        if ((c inside {1, 2, 6, 7, 8}) && w[11:7] == 0 && (w[19:15] != 0 || w[24:20] != 0))
            c = 15;
        return c;
    endfunction

    function automatic exp_t ref_bundle(input logic [32*L-1:0] w, input logic [L-1:0] f,
                                        input logic [31:0] p);
        exp_t e;
        bit dead = 1'b0;
        e.inst = w; e.pc = p; e.cls = '0; e.rw = '0; e.ill = '0;
        for (int k = 0; k < L; k++) begin
            int c = (f[k] && !dead) ? ref_cls(w[32*k +: 32]) : 0;
            e.cls[4*k +: 4] = 4'(c);
            e.rw[k]  = c inside {1, 2, 3, 4, 6, 7, 8};
            e.ill[k] = (c == 15);
            if (c == 15) dead = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [8] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33, 7'h7F};
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h5A};
        logic [31:0] w = $urandom;
        w[6:0] = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
        if ($urandom_range(0, 15) == 0) w = 32'h0000_0013;
        return w;
    endfunction

    // Model: a FIFO of at most two decoded bundles.
    initial forever begin
        bit ready_m, ov_m;
        @(posedge clk);
        ready_m = (q.size() < 2);
        ov_m    = (q.size() > 0);
        if (rst) begin
            q.delete();
            m_cnt  = 0;
            chk_en = 1'b1;
        end else begin
            if (ov_m && out_ready) begin
                m_cnt = m_cnt + $countones(q[0].ill);
                if (m_cnt > SAT) m_cnt = SAT;
                void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (in_valid && ready_m) q.push_back(ref_bundle(inst, fetched, pc));
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("illegal_cnt", 64'(cnt), 64'(m_cnt));
            if (q.size() > 0) begin
                check("out_inst", 64'(out_inst), 64'(q[0].inst));
                check("out_cls", 64'(out_cls), 64'(q[0].cls));
                check("out_regwrite", 64'(out_rw), 64'(q[0].rw));
                check("out_illegal", 64'(out_ill), 64'(q[0].ill));
                check("out_pc", 64'(out_pc), 64'(q[0].pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int need;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; fetched = '0; pc = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_cls", 64'(out_cls), 64'd0);

        // addi x1,x0,5 | jal x0,0
        inst = {32'h0000_006F, 32'h0050_0093}; fetched = 2'b11; pc = 32'h100;
        in_valid = 1'b1; out_ready = 1'b1;
        tick(); in_valid = 1'b0;
        check("t1_cls", 64'(out_cls), 64'h36);
        check("t1_rw", 64'(out_rw), 64'h3);
        check("t1_ill", 64'(out_ill), 64'h0);
        check("t1_pc", 64'(out_pc), 64'h100);

        // add x0,x1,x2 is illegal, lane 1 squashed
        inst = {32'h0050_0093, 32'h0020_8033}; pc = 32'h108; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        check("t2_cls", 64'(out_cls), 64'h0F);
        check("t2_ill", 64'(out_ill), 64'h1);
        check("t2_cnt_before", 64'(cnt), 64'd0);
        tick();
        check("t2_cnt_after", 64'(cnt), 64'd1);

        // back-pressure: A in main, B in skid, C refused until space frees
        out_ready = 1'b0; inst = {32'h0000_0013, 32'h0050_0093};
        pc = 32'h200; in_valid = 1'b1; tick();
        pc = 32'h204; tick();
        check("t3_in_ready_full", 64'(in_ready), 64'd0);
        pc = 32'h208; tick();
        check("t3_hold_a", 64'(out_pc), 64'h200);
        check("t3_c_refused", 64'(in_ready), 64'd0);
        out_ready = 1'b1; tick();
        check("t3_b", 64'(out_pc), 64'h204);
        check("t3_ready_back", 64'(in_ready), 64'd1);
        tick(); in_valid = 1'b0;
        check("t3_c", 64'(out_pc), 64'h208);
        tick();
        check("t3_empty", 64'(out_valid), 64'd0);

        // flush with both entries full and a bundle on the input
        out_ready = 1'b0; in_valid = 1'b1;
        pc = 32'h300; tick();
        pc = 32'h304; tick();
        pc = 32'h308; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            check("t4_stays_empty", 64'(out_valid), 64'd0);
        end

        // mul x3,x1,x2 and fetch gating
        inst = {32'h0000_0013, 32'h0220_81B3}; fetched = 2'b01; pc = 32'h400;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
`ifdef DECODE_RVM_EN
        check("t5_mul_cls", 64'(out_cls), 64'h08);
        check("t5_mul_ill", 64'(out_ill), 64'h0);
`else
        check("t5_mul_cls", 64'(out_cls), 64'h0F);
        check("t5_mul_ill", 64'(out_ill), 64'h1);
`endif
        inst = {32'h0000_0013, 32'h0000_0013}; fetched = 2'b10;
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("t5_unfetched_cls", 64'(out_cls), 64'h60);
        check("t5_unfetched_ill", 64'(out_ill), 64'h0);
        tick();

        // counter saturation: walk to all-ones minus one, then overflow it
        need = (SAT - 1) - m_cnt;
        inst = {32'h0000_0013, 32'hFFFF_FFFF}; fetched = 2'b11;
        in_valid = 1'b1;
        repeat (need) tick();
        in_valid = 1'b0; tick(); tick();
        check("t6_cnt_near", 64'(cnt), 64'(SAT - 1));
        in_valid = 1'b1; repeat (3) tick();
        in_valid = 1'b0; tick(); tick();
        check("t6_cnt_sat", 64'(cnt), 64'(SAT));

        // randomized traffic, including flushes and mid-run resets
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 9) < 6);
            fetched   = L'($urandom);
            inst      = {rand_inst(), rand_inst()};
            pc        = $urandom;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
